// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-ported synchronous RAM: accept, access, respond.
// Optional macro RAM_ARBITER_ROUND_ROBIN_EN replaces fixed priority (req1 wins) with round robin.
module ram_arbiter #(
   parameter int unsigned AddressWidth = 16,
   parameter int unsigned DataWidth    = 32
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_req0_valid,
   input  logic                    i_req0_write,
   input  logic [AddressWidth-1:0] i_req0_address,
   input  logic [DataWidth-1:0]    i_req0_write_data,
   input  logic                    i_req1_valid,
   input  logic                    i_req1_write,
   input  logic [AddressWidth-1:0] i_req1_address,
   input  logic [DataWidth-1:0]    i_req1_write_data,
   output logic                    o_req0_ready,
   output logic                    o_req0_done,
   output logic [DataWidth-1:0]    o_req0_read_data,
   output logic                    o_req1_ready,
   output logic                    o_req1_done,
   output logic [DataWidth-1:0]    o_req1_read_data,
   output logic                    o_mem_enable,
   output logic                    o_mem_write_enable,
   output logic [AddressWidth-1:0] o_mem_address,
   output logic [DataWidth-1:0]    o_mem_write_data,
   input  logic [DataWidth-1:0]    i_mem_read_data
);

   localparam logic [1:0] StIdle    = 2'd0;
   localparam logic [1:0] StAccess  = 2'd1;
   localparam logic [1:0] StRespond = 2'd2;

   logic [1:0]              state_q, state_d;
   logic                    grant_q, grant_d;
   logic                    write_q, write_d;
   logic [AddressWidth-1:0] address_q, address_d;
   logic [DataWidth-1:0]    write_data_q, write_data_d;
   logic                    any_valid;
   logic                    grant_win;

   assign any_valid = i_req0_valid | i_req1_valid;

`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   logic last_grant_q;

   // On contention the requester not served last wins; a lone requester always wins.
   assign grant_win = (i_req0_valid && i_req1_valid) ? ~last_grant_q : i_req1_valid;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         last_grant_q <= 1'b0;
      end else if (state_q == StIdle && any_valid) begin
         last_grant_q <= grant_win;
      end
   end
`else
   assign grant_win = i_req1_valid;
`endif

   always_comb begin
      state_d            = state_q;
      grant_d            = grant_q;
      write_d            = write_q;
      address_d          = address_q;
      write_data_d       = write_data_q;
      o_req0_ready       = 1'b0;
      o_req1_ready       = 1'b0;
      o_req0_done        = 1'b0;
      o_req1_done        = 1'b0;
      o_req0_read_data   = '0;
      o_req1_read_data   = '0;
      o_mem_enable       = 1'b0;
      o_mem_write_enable = 1'b0;
      o_mem_address      = '0;
      o_mem_write_data   = '0;
      // Reset forces every output low, including an abandoned ACCESS or RESPOND.
      if (!i_reset) begin
         case (state_q)
            StIdle: begin
               if (any_valid) begin
                  o_req0_ready = ~grant_win;
                  o_req1_ready = grant_win;
                  grant_d      = grant_win;
                  write_d      = grant_win ? i_req1_write : i_req0_write;
                  address_d    = grant_win ? i_req1_address : i_req0_address;
                  write_data_d = grant_win ? i_req1_write_data : i_req0_write_data;
                  state_d      = StAccess;
               end
            end
            StAccess: begin
               o_mem_enable       = 1'b1;
               o_mem_write_enable = write_q;
               o_mem_address      = address_q;
               o_mem_write_data   = write_data_q;
               state_d            = StRespond;
            end
            StRespond: begin
               o_req0_done = ~grant_q;
               o_req1_done = grant_q;
               if (!write_q) begin
                  if (grant_q) begin
                     o_req1_read_data = i_mem_read_data;
                  end else begin
                     o_req0_read_data = i_mem_read_data;
                  end
               end
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q      <= StIdle;
         grant_q      <= 1'b0;
         write_q      <= 1'b0;
         address_q    <= '0;
         write_data_q <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         write_q      <= write_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a cycle-count
// transaction model and a behavioural RAM. Honours RAM_ARBITER_ROUND_ROBIN_EN.
module tb_ram_arbiter;

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
`ifdef RAM_ARBITER_ROUND_ROBIN_EN
   localparam bit RoundRobin = 1'b1;
`else
   localparam bit RoundRobin = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          v0 = 1'b0, w0 = 1'b0, v1 = 1'b0, w1 = 1'b0;
   logic [AW-1:0] a0 = '0, a1 = '0;
   logic [DW-1:0] d0 = '0, d1 = '0;
   logic          ready0, ready1, done0, done1, mem_en, mem_we;
   logic [DW-1:0] rd0, rd1, mem_wd, mem_rd;
   logic [AW-1:0] mem_addr;

   always #5 clk = ~clk;

   ram_arbiter #(.AddressWidth(AW), .DataWidth(DW)) dut (
      .i_clock            (clk),
      .i_reset            (rst),
      .i_req0_valid       (v0),
      .i_req0_write       (w0),
      .i_req0_address     (a0),
      .i_req0_write_data  (d0),
      .i_req1_valid       (v1),
      .i_req1_write       (w1),
      .i_req1_address     (a1),
      .i_req1_write_data  (d1),
      .o_req0_ready       (ready0),
      .o_req0_done        (done0),
      .o_req0_read_data   (rd0),
      .o_req1_ready       (ready1),
      .o_req1_done        (done1),
      .o_req1_read_data   (rd1),
      .o_mem_enable       (mem_en),
      .o_mem_write_enable (mem_we),
      .o_mem_address      (mem_addr),
      .o_mem_write_data   (mem_wd),
      .i_mem_read_data    (mem_rd)
   );

   // Behavioural synchronous RAM on the memory side, with a preload port for initial contents.
   logic [DW-1:0] ram [256];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always_ff @(posedge clk) begin
      if (pl_en) begin
         ram[pl_addr] <= pl_data;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wd;
         mem_rd <= ram[mem_addr];
      end
   end

   // Reference model state
   logic [DW-1:0] ref_mem [256];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   bit            busy = 0;
   int            t_acc = 0;
   bit            t_grant, t_write, last_grant = 0;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rd;
   bit            acc0, acc1, hold = 0;
   int            done_log[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven; checks this cycle, advances one cycle.
   task automatic step();
      logic          e_r0, e_r1, e_en, e_we, e_d0, e_d1, win;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rd0, e_rd1;
      {e_r0, e_r1, e_en, e_we, e_d0, e_d1} = '0;
      e_addr = '0;
      e_wd   = '0;
      e_rd0  = '0;
      e_rd1  = '0;
      acc0   = 0;
      acc1   = 0;
      #1;
      if (rst) begin
         busy       = 0;
         last_grant = 0;
      end else if (busy && cyc == t_acc + 1) begin
         e_en   = 1'b1;
         e_we   = t_write;
         e_addr = t_addr;
         e_wd   = t_wdata;
         if (t_write) ref_mem[t_addr] = t_wdata;
         else t_rd = ref_mem[t_addr];
      end else if (busy && cyc == t_acc + 2) begin
         if (t_grant) begin
            e_d1  = 1'b1;
            e_rd1 = t_write ? '0 : t_rd;
         end else begin
            e_d0  = 1'b1;
            e_rd0 = t_write ? '0 : t_rd;
         end
         busy = 0;
      end else if (v0 || v1) begin
         if (v0 && v1) win = RoundRobin ? ~last_grant : 1'b1;
         else win = v1;
         busy       = 1;
         t_acc      = cyc;
         t_grant    = win;
         last_grant = win;
         t_write    = win ? w1 : w0;
         t_addr     = win ? a1 : a0;
         t_wdata    = win ? d1 : d0;
         e_r0       = ~win;
         e_r1       = win;
         acc0       = ~win;
         acc1       = win;
      end
      chk("ready0", 32'(ready0), 32'(e_r0));
      chk("ready1", 32'(ready1), 32'(e_r1));
      chk("mem_enable", 32'(mem_en), 32'(e_en));
      chk("mem_write_enable", 32'(mem_we), 32'(e_we));
      chk("mem_address", 32'(mem_addr), 32'(e_addr));
      chk("mem_write_data", 32'(mem_wd), 32'(e_wd));
      chk("done0", 32'(done0), 32'(e_d0));
      chk("done1", 32'(done1), 32'(e_d1));
      chk("read_data0", 32'(rd0), 32'(e_rd0));
      chk("read_data1", 32'(rd1), 32'(e_rd1));
      if (done0 === 1'b1) done_log.push_back(0);
      if (done1 === 1'b1) done_log.push_back(1);
      cyc++;
      @(posedge clk);
      @(negedge clk);
      if (acc0 && !hold) v0 = 1'b0;
      if (acc1 && !hold) v1 = 1'b0;
   endtask

   initial begin
      int exp_grants[4];
      // Preload addresses 0..31 in both the RAM and the reference copy
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         pl_en      = 1'b1;
         pl_addr    = AW'(i);
         pl_data    = (i == 16) ? 8'hA5 : DW'($urandom);
         ref_mem[i] = pl_data;
         @(negedge clk);
      end
      pl_en = 1'b0;

      // Reset then idle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      repeat (5) step();

      // Single read by req0 of 0x10 (holds 0xA5)
      v0 = 1'b1; w0 = 1'b0; a0 = 8'h10; d0 = 8'h00;
      repeat (3) step();

      // Write 0x3C to 0x04 from req1, then read it back
      v1 = 1'b1; w1 = 1'b1; a1 = 8'h04; d1 = 8'h3C;
      repeat (3) step();
      v1 = 1'b1; w1 = 1'b0; a1 = 8'h04; d1 = 8'h00;
      done_log.delete();
      repeat (3) step();
      chk("readback_done_count", 32'(done_log.size()), 32'd1);

      // Contention: both valid continuously, arbitration pointer freshly reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      hold = 1;
      v0 = 1'b1; w0 = 1'b0; a0 = 8'h01;
      v1 = 1'b1; w1 = 1'b0; a1 = 8'h02;
      done_log.delete();
      for (int k = 0; k < 30 && done_log.size() < 4; k++) step();
      chk("contention_done_count", 32'(done_log.size()), 32'd4);
      exp_grants = RoundRobin ? '{1, 0, 1, 0} : '{1, 1, 1, 1};
      if (done_log.size() >= 4) begin
         for (int k = 0; k < 4; k++) chk($sformatf("contention_grant%0d", k),
                                         32'(done_log[k]), 32'(exp_grants[k]));
      end
      hold = 0;
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (4) step();

      // Reset during ACCESS of a req0 read: no done0, then a normal transaction
      done_log.delete();
      v0 = 1'b1; w0 = 1'b0; a0 = 8'h10;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (3) step();
      chk("abandoned_done_count", 32'(done_log.size()), 32'd0);
      v1 = 1'b1; w1 = 1'b0; a1 = 8'h10;
      repeat (3) step();
      chk("post_reset_done_count", 32'(done_log.size()), 32'd1);

      // Random traffic over a small address window with occasional resets
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         if (!v0 && $urandom_range(0, 1) == 1) begin
            v0 = 1'b1; w0 = 1'($urandom_range(0, 1));
            a0 = AW'($urandom_range(0, 15)); d0 = DW'($urandom);
         end
         if (!v1 && $urandom_range(0, 1) == 1) begin
            v1 = 1'b1; w1 = 1'($urandom_range(0, 1));
            a1 = AW'($urandom_range(0, 15)); d1 = DW'($urandom);
         end
         step();
      end
      rst = 1'b0;
      v0 = 1'b0;
      v1 = 1'b0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares one single-ported synchronous RAM between two CPU-side requesters: requester 0 (instruction fetch) and requester 1 (data load/store).
- Accepts one request at a time over a valid/ready handshake and registers it.
- Drives the memory-side enable/write_enable/address/write_data lines for exactly one cycle.
- Returns a one-cycle done pulse, with read data for reads, to the granted requester.
- Sits between the CPU core and the RAM port's Memory side.

Parameters:
AddressWidth, Isa::MEMORY_ADDRESS_WIDTH, width of every address bus
DataWidth, Isa::MEMORY_DATA_WIDTH, width of every data bus

Ports:
i_clock  input  1  system clock; all state updates on rising edge
i_reset  input  1  synchronous, active-high reset
i_req0_valid / i_req1_valid  input  1  requester N has a pending request
i_req0_write / i_req1_write  input  1  1 = write, 0 = read
i_req0_address / i_req1_address  input  AddressWidth  request address
i_req0_write_data / i_req1_write_data  input  DataWidth  write payload
o_req0_ready / o_req1_ready  output  1  request accepted this cycle
o_req0_done / o_req1_done  output  1  one-cycle completion pulse
o_req0_read_data / o_req1_read_data  output  DataWidth  read result, valid while done is 1 for a read
o_mem_enable  output  1  memory enable
o_mem_write_enable  output  1  memory write enable
o_mem_address  output  AddressWidth  memory address
o_mem_write_data  output  DataWidth  memory write data
i_mem_read_data  input  DataWidth  memory read data; valid the cycle after enable (synchronous read)

Behaviour:
- Clocking and reset: one clock, i_clock. Reset is synchronous and active-high on i_reset.
- Reset values:
  - FSM goes to IDLE.
  - All o_* outputs are 0: ready, done, mem enable/write_enable, address, write_data and read_data.
  - Round-robin pointer (optional feature) is set to requester 0.
- FSM states: IDLE -> ACCESS -> RESPOND -> IDLE. There are no other states. Encodings outside these three return to IDLE.
- IDLE:
  - If any i_reqN_valid is 1, select a winner (arbitration below).
  - o_reqW_ready is combinationally 1 for the winner only, in the same cycle.
  - On the clock edge, latch the winner's write/address/write_data and the grant ID, then go to ACCESS.
  - If no request is valid, stay in IDLE; all ready outputs are 0.
- ACCESS:
  - o_mem_enable = 1, o_mem_write_enable = latched write, address and data taken from the latch.
  - Exactly one cycle long, then go to RESPOND.
- RESPOND:
  - o_reqW_done = 1 for the granted requester only.
  - For a read, o_reqW_read_data = i_mem_read_data, passed combinationally this cycle.
  - For a write, read_data is 0.
  - o_mem_enable = 0. Next state is IDLE.
- Outside ACCESS: memory outputs are 0.
- Outside RESPOND: done and read_data outputs are 0.
- Latency: accept at cycle T, memory access at T+1, done at T+2. Peak throughput is one transaction per 3 cycles.
- Requester rules:
  - A requester holds valid and its payload until ready is seen.
  - Changes to payload while not ready are ignored.
  - Valid held after acceptance is treated as a new request, eligible from the next IDLE.
- Arbitration (default, fixed priority): requester 1 (data) beats requester 0 (fetch) when both are valid in IDLE.
- Reset mid-operation (ACCESS or RESPOND):
  - The in-flight transaction is abandoned and no done pulse is issued.
  - A write in ACCESS may or may not have reached memory.
  - Next cycle, state is IDLE.
- Widths: all paths pass through at their full parameter width. No arithmetic is performed.

Optional Feature:
- Macro: RAM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last-grant register, reset to 0, updated on every acceptance.
  - When both requesters are valid, the requester not granted last wins.
  - A single valid requester always wins.
- Undefined: fixed priority, with requester 1 always winning. The register is not present.

Test Plan:
- Reset then idle: assert i_reset 2 cycles, no requests -> every o_* is 0 for 5 cycles; no mem enable.
- Single read: req0 read of address 0x10, where RAM[0x10]=0xA5 -> ready0 at T, mem enable with address 0x10 and write_enable=0 at T+1, done0=1 and read_data0=0xA5 at T+2, done1=0 throughout.
- Write then read-back: req1 writes 0x3C to 0x04, then reads 0x04 -> write done1 at T+2 with mem write_enable=1 at T+1; read returns 0x3C at T'+2.
- Contention: both valid continuously for 4 transactions ->
  - Without the macro, grants are 1,1,1,1.
  - With RAM_ARBITER_ROUND_ROBIN_EN, grants are 1,0,1,0 (pointer reset to 0 means req1 wins first).
- Reset mid-operation: assert i_reset during ACCESS of a req0 read -> no done0 is ever issued, FSM is in IDLE the next cycle, and a subsequent request completes normally in 3 cycles.
